// File: rtl/uart_rx_if.sv
// Receive-side parallel bus of the UART receiver.
// The receiver drives it through the master modport; the consumer (FIFO or
// command parser) reads it through the slave modport.
// When UART_RX_PARITY_EN is defined, the bus also carries o_parity_err.
interface uart_rx_if #(
   parameter int DATA_BITS = 8
);

   logic [DATA_BITS-1:0] o_data;
   logic                 o_rx_valid;
   logic                 o_rx_busy;
   logic                 o_frame_err;
   logic                 o_tick_debug;
`ifdef UART_RX_PARITY_EN
   logic                 o_parity_err;
`endif

   modport master (
      output o_data,
      output o_rx_valid,
      output o_rx_busy,
      output o_frame_err,
      output o_tick_debug
`ifdef UART_RX_PARITY_EN
      ,
      output o_parity_err
`endif
   );

   modport slave (
      input o_data,
      input o_rx_valid,
      input o_rx_busy,
      input o_frame_err,
      input o_tick_debug
`ifdef UART_RX_PARITY_EN
      ,
      input o_parity_err
`endif
   );

endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled 8N1 frame recovery with a one-cycle valid
// strobe, framing-error strobe and bit-centre debug strobe.
// Optional feature macro: UART_RX_PARITY_EN
//    adds a parity bit between the data bits and the stop bit, the
//    PARITY_ODD parameter, and the o_parity_err strobe on the bus.
// All outputs are registered.
module uart_rx #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic      i_clk,
   input  logic      rst,
   input  logic      i_rx_serial,
   uart_rx_if.master bus
);

   // Tick divider: one oversample tick every DIV system clocks.
   localparam int DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
   localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
`ifdef UART_RX_PARITY_EN
      ,
      PARITY    = 3'd5
`endif
   } state_t;

`ifdef UART_RX_PARITY_EN
   // True when data plus parity bit does not carry the selected parity.
   function automatic logic parity_bad(input logic [DATA_BITS-1:0] d,
                                       input logic p,
                                       input logic odd);
      return ((^d) ^ p) != odd;
   endfunction
`endif

   // Synchronizer and line-state tracking.
   logic       rx_meta;
   logic       rx_s;
   logic [1:0] sync_fill;
   logic       armed;
   logic       armed_nx;

   // Tick generator.
   logic [DIV_W-1:0] div_cnt;
   logic             tick;

   // FSM and datapath.
   state_t               state;
   state_t               state_nx;
   logic [TICK_W-1:0]    tick_cnt;
   logic [TICK_W-1:0]    tick_cnt_nx;
   logic [IDX_W-1:0]     bit_idx;
   logic [IDX_W-1:0]     bit_idx_nx;
   logic [DATA_BITS-1:0] shift;
   logic [DATA_BITS-1:0] shift_nx;
   logic [DATA_BITS-1:0] data;
   logic [DATA_BITS-1:0] data_nx;
   logic                 valid;
   logic                 valid_nx;
   logic                 busy;
   logic                 busy_nx;
   logic                 ferr;
   logic                 ferr_nx;
   logic                 tick_dbg;
   logic                 tick_dbg_nx;
`ifdef UART_RX_PARITY_EN
   logic                 par_bit;
   logic                 par_bit_nx;
   logic                 perr;
   logic                 perr_nx;
`endif

   // Two-flop synchronizer, idle-high; sync_fill marks when rx_s reflects the pin.
   always_ff @(posedge i_clk or posedge rst) begin
      if (rst) begin
         rx_meta   <= 1'b1;
         rx_s      <= 1'b1;
         sync_fill <= 2'b00;
      end else begin
         rx_meta   <= i_rx_serial;
         rx_s      <= rx_meta;
         sync_fill <= {sync_fill[0], 1'b1};
      end
   end

   // Free-running oversample tick divider, never realigned to the frame.
   always_ff @(posedge i_clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   assign tick = (div_cnt == DIV_LAST);

   // FSM state register.
   always_ff @(posedge i_clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state, datapath and output-strobe decode.
   always_comb begin
      state_nx    = state;
      tick_cnt_nx = tick_cnt;
      bit_idx_nx  = bit_idx;
      shift_nx    = shift;
      data_nx     = data;
      valid_nx    = 1'b0;
      busy_nx     = busy;
      ferr_nx     = 1'b0;
      tick_dbg_nx = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_nx  = par_bit;
      perr_nx     = 1'b0;
`endif

      // A start edge is only trusted after the real line has been seen high,
      // so a frame cut by reset is ignored until the line idles again.
      if (sync_fill[1] && rx_s) begin
         armed_nx = 1'b1;
      end else begin
         armed_nx = armed;
      end

      case (state)
         IDLE: begin
            if (tick && !rx_s && armed) begin
               state_nx    = START;
               tick_cnt_nx = '0;
               armed_nx    = 1'b0;
            end else begin
               state_nx = IDLE;
            end
         end

         START: begin
            if (tick) begin
               if (tick_cnt == HALF_LAST) begin
                  tick_cnt_nx = '0;
                  if (!rx_s) begin
                     busy_nx     = 1'b1;
                     tick_dbg_nx = 1'b1;
                     bit_idx_nx  = '0;
                     state_nx    = DATA;
                  end else begin
                     // Glitch shorter than half a bit: not a start bit.
                     state_nx = IDLE;
                  end
               end else begin
                  tick_cnt_nx = tick_cnt + TICK_W'(1);
               end
            end else begin
               state_nx = START;
            end
         end

         DATA: begin
            if (tick) begin
               if (tick_cnt == FULL_LAST) begin
                  tick_cnt_nx       = '0;
                  tick_dbg_nx       = 1'b1;
                  shift_nx[bit_idx] = rx_s;
                  if (bit_idx == IDX_LAST) begin
                     bit_idx_nx = '0;
`ifdef UART_RX_PARITY_EN
                     state_nx   = PARITY;
`else
                     state_nx   = STOP;
`endif
                  end else begin
                     bit_idx_nx = bit_idx + IDX_W'(1);
                  end
               end else begin
                  tick_cnt_nx = tick_cnt + TICK_W'(1);
               end
            end else begin
               state_nx = DATA;
            end
         end

`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tick) begin
               if (tick_cnt == FULL_LAST) begin
                  tick_cnt_nx = '0;
                  tick_dbg_nx = 1'b1;
                  par_bit_nx  = rx_s;
                  state_nx    = STOP;
               end else begin
                  tick_cnt_nx = tick_cnt + TICK_W'(1);
               end
            end else begin
               state_nx = PARITY;
            end
         end
`endif

         STOP: begin
            if (tick) begin
               if (tick_cnt == FULL_LAST) begin
                  tick_cnt_nx = '0;
                  tick_dbg_nx = 1'b1;
                  busy_nx     = 1'b0;
                  if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                     if (parity_bad(shift, par_bit, PARITY_ODD)) begin
                        perr_nx = 1'b1;
                     end else begin
                        data_nx  = shift;
                        valid_nx = 1'b1;
                     end
`else
                     data_nx  = shift;
                     valid_nx = 1'b1;
`endif
                     state_nx = IDLE;
                  end else begin
                     // Framing error wins over parity: only ferr is reported.
                     ferr_nx  = 1'b1;
                     state_nx = WAIT_IDLE;
                  end
               end else begin
                  tick_cnt_nx = tick_cnt + TICK_W'(1);
               end
            end else begin
               state_nx = STOP;
            end
         end

         WAIT_IDLE: begin
            // Break or stuck-low line: hold off until it returns high.
            if (rx_s) begin
               state_nx = IDLE;
            end else begin
               state_nx = WAIT_IDLE;
            end
         end

         default: begin
            state_nx    = IDLE;
            tick_cnt_nx = '0;
            bit_idx_nx  = '0;
            busy_nx     = 1'b0;
         end
      endcase
   end

   // Datapath and registered output strobes.
   always_ff @(posedge i_clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         data     <= '0;
         valid    <= 1'b0;
         busy     <= 1'b0;
         ferr     <= 1'b0;
         tick_dbg <= 1'b0;
         armed    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit  <= 1'b0;
         perr     <= 1'b0;
`endif
      end else begin
         tick_cnt <= tick_cnt_nx;
         bit_idx  <= bit_idx_nx;
         shift    <= shift_nx;
         data     <= data_nx;
         valid    <= valid_nx;
         busy     <= busy_nx;
         ferr     <= ferr_nx;
         tick_dbg <= tick_dbg_nx;
         armed    <= armed_nx;
`ifdef UART_RX_PARITY_EN
         par_bit  <= par_bit_nx;
         perr     <= perr_nx;
`endif
      end
   end

   assign bus.o_data       = data;
   assign bus.o_rx_valid   = valid;
   assign bus.o_rx_busy    = busy;
   assign bus.o_frame_err  = ferr;
   assign bus.o_tick_debug = tick_dbg;
`ifdef UART_RX_PARITY_EN
   assign bus.o_parity_err = perr;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the UART transmitter in the same serial link block.
- Oversamples the asynchronous serial line at 16x the baud rate and recovers 8N1 frames (start, data LSB-first, stop).
- Presents each received byte on a parallel bus with a one-cycle valid strobe.
- Sits between the board RX pin and the consumer logic (FIFO or command parser).

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- OVERSAMPLE, 16, sample ticks per bit period; must be even and at least 8.
- DATA_BITS, 8, data bits per frame, in the range 5 to 8.

Ports:
- i_clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- i_rx_serial  input  1  asynchronous serial line; idle level is 1.
- o_data  output  DATA_BITS  last correctly received byte; held until the next good frame.
- o_rx_valid  output  1  one-cycle pulse when o_data is updated.
- o_rx_busy  output  1  high from start-bit confirmation until the stop bit has been sampled.
- o_frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
- o_tick_debug  output  1  one-cycle pulse at every bit-centre sampling instant (start, data, stop).

Behaviour:
- Reset state:
  - All outputs are 0, FSM is in IDLE, counters are 0.
  - Synchronizer flops reset to 1 (line idle).
- Reset is asynchronous and wins over every other event, including mid-frame. After release the block is in IDLE and ignores the rest of the interrupted frame until it sees the line high, then low again.
- Input synchronization:
  - i_rx_serial passes through a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
  - Latency from pin to rx_s is 2 cycles.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer floor (default 27).
  - Counter runs 0..DIV-1; a tick pulses for one cycle when the count equals DIV-1.
  - The counter free-runs and is never realigned to the frame.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: when rx_s is 0 on a tick, go to START and clear the sample counter.
  - START: count ticks. At tick OVERSAMPLE/2-1 (the bit centre), sample rx_s.
    - If rx_s is 0, set o_rx_busy, pulse o_tick_debug, clear the sample counter and bit index, and go to DATA.
    - If rx_s is 1, this is a false start: return to IDLE with no outputs changed.
  - DATA: every OVERSAMPLE ticks, sample rx_s into shift bit [index], LSB first, and pulse o_tick_debug. After bit DATA_BITS-1, go to STOP.
  - STOP: after OVERSAMPLE ticks, sample rx_s and pulse o_tick_debug.
    - If rx_s is 1: on the next cycle, load o_data from the shift register, pulse o_rx_valid, clear o_rx_busy, and go to IDLE.
    - If rx_s is 0: on the next cycle, pulse o_frame_err, leave o_data unchanged, clear o_rx_busy, and go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s is 1 (break or line-stuck-low condition), then go to IDLE. No new frame is accepted before then.
- Back-to-back frames: a start bit that begins right after the stop-bit centre is detected. There is no dead time beyond half a bit.
- o_rx_valid and o_frame_err are never high in the same cycle.
- Total latency from the stop-bit centre to o_rx_valid is 1 cycle.

Optional Feature:
- Macro name: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP; the parity bit is sampled at its bit centre, with an o_tick_debug pulse.
  - Parameter PARITY_ODD (default 0) selects even (0) or odd (1) parity.
  - Added output o_parity_err (1 bit) pulses in the same cycle o_rx_valid would otherwise fire when parity mismatches. In that case o_rx_valid does not pulse and o_data is not updated.
  - A framing error takes precedence: only o_frame_err pulses.
- When not defined: no PARITY state, no o_parity_err port, frames are 8N1.

Test Plan:
- Nominal byte: after rst is released, drive frame 0x61 at 115200 baud (0, 1,0,0,0,0,1,1,0, 1). Required: one o_rx_valid pulse with o_data=0x61, o_frame_err=0, 10 o_tick_debug pulses, o_rx_busy low afterwards.
- Back-to-back: send 0x00 then 0xFF with zero idle between frames. Required: two o_rx_valid pulses, carrying 0x00 then 0xFF.
- False start: low glitch of 3 oversample ticks (~1.7 us), then line high. Required: no o_rx_valid, o_rx_busy stays 0, FSM is back in IDLE. A following 0xA5 is received correctly.
- Framing error: send 0x3C with stop bit 0, hold low for 2 bit times, then release. Required: one o_frame_err pulse, o_data still holds the previous value, no reception until the line goes high. A following 0x55 is received correctly.
- Reset mid-frame: assert rst during data bit 4 of 0x81. Required: all outputs 0 immediately (asynchronous). Frame remainder produces no o_rx_valid. The next full frame 0x7E is received correctly.
- With UART_RX_PARITY_EN (even parity): 0x61 with parity bit 1 gives o_rx_valid with 0x61. 0x61 with parity bit 0 gives one o_parity_err pulse and no o_rx_valid.
